pc_branch_sequencer: RTL and testbench

//  Owns the program counter and drives the select of the branch/PC+1 mux in fetch.

---
 rtl/pc_branch_sequencer_if.sv | 26 ++
 rtl/pc_branch_sequencer.sv | 101 ++++++++++
 tb/tb_pc_branch_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_branch_sequencer_if.sv
// Fetch-control bundle between branch resolution, the PC sequencer and the fetch mux.
// branch_count is not part of this bundle; it only exists when BRANCH_STATS_EN is defined.
interface pc_branch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              stall;
  logic              branch_req;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;
  logic              resume;
  logic [ADDR_W-1:0] pc;
  logic              mux_sel;
  logic              fetch_valid;
  logic              flush;
  logic              halted;

  modport master (
    output stall, branch_req, branch_target, halt, resume,
    input  pc, mux_sel, fetch_valid, flush, halted
  );

  modport slave (
    input  stall, branch_req, branch_target, halt, resume,
    output pc, mux_sel, fetch_valid, flush, halted
  );
endinterface

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: picks redirect / increment / hold / halt each cycle, flushes after branches.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module pc_branch_sequencer #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pc_branch_sequencer_if.slave    bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]             branch_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [3:0]        flush_cnt_reg, flush_cnt_next;
  logic              mux_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      pc_reg        <= RESET_PC;
      flush_cnt_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    flush_cnt_next = flush_cnt_reg;
    mux_sel        = 1'b0;
    case (state_reg)
      RUN: begin
        // halt outranks a redirect; a redirect outranks a stall so it is never lost
        if (bus.halt) begin
          state_next = HALT;
        end else if (bus.branch_req) begin
          mux_sel        = 1'b1;
          pc_next        = bus.branch_target;
          flush_cnt_next = FLUSH_LOAD;
          state_next     = FLUSH;
        end else if (!bus.stall) begin
          pc_next = pc_reg + ADDR_W'(1);
        end
      end
      FLUSH: begin
        flush_cnt_next = flush_cnt_reg - 4'd1;
        if (flush_cnt_reg <= 4'd1) begin
          state_next = RUN;
        end
      end
      HALT: begin
        if (bus.resume && !bus.halt) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign bus.pc          = pc_reg;
  assign bus.mux_sel     = mux_sel;
  assign bus.fetch_valid = (state_reg == RUN);
  assign bus.flush       = (state_reg == FLUSH);
  assign bus.halted      = (state_reg == HALT);

`ifdef BRANCH_STATS_EN
  logic        branch_accept;
  logic [15:0] branch_count_reg;

  assign branch_accept = (state_reg == RUN) && !bus.halt && bus.branch_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_reg <= 16'd0;
    end else if (branch_accept && (branch_count_reg != 16'hFFFF)) begin
      branch_count_reg <= branch_count_reg + 16'd1;
    end
  end

  assign branch_count = branch_count_reg;
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Scoreboard bench for pc_branch_sequencer (RESET_PC=0, FLUSH_CYCLES=2).
module tb_pc_branch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pc_branch_sequencer_if #(.ADDR_W(32)) bus ();

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count;
`endif

  pc_branch_sequencer #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef BRANCH_STATS_EN
    ,
    .branch_count(branch_count)
`endif
  );

  // mux is sampled in the stimulus cycle; pc/fv/fl/hl just after the following edge
  typedef struct packed {
    logic [31:0] pc;
    logic        mux;
    logic        fv;
    logic        fl;
    logic        hl;
  } rec_t;

  rec_t sb[$];
  rec_t obs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic rec_t mk(input logic [31:0] p, input logic m, fv, fl, hl);
    rec_t r;
    r.pc = p; r.mux = m; r.fv = fv; r.fl = fl; r.hl = hl;
    return r;
  endfunction

  // Drive one cycle of stimulus, push the expectation and record what the DUT did.
  task automatic apply(input logic st, br, input logic [31:0] tgt,
                       input logic hl_in, rs, input rec_t e);
    rec_t o;
    bus.stall = st; bus.branch_req = br; bus.branch_target = tgt;
    bus.halt = hl_in; bus.resume = rs;
    #1;
    o.mux = bus.mux_sel;
    @(posedge clk);
    #1;
    o.pc = bus.pc; o.fv = bus.fetch_valid; o.fl = bus.flush; o.hl = bus.halted;
    sb.push_back(e);
    obs.push_back(o);
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.branch_req = 1'b0; bus.branch_target = '0;
    bus.halt = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic test_reset();
    rec_t e, o;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.pc, bus.flush, bus.halted} !== {32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got pc=%h flush=%b halted=%b, need pc=0 flush=0 halted=0",
               bus.pc, bus.flush, bus.halted);
    end else $display("ok   reset_values pc=%h", bus.pc);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.fetch_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fetch_valid: got %b, need 1", bus.fetch_valid);
    end else $display("ok   reset_fetch_valid");
    for (int i = 1; i <= 4; i++) apply(0, 0, 0, 0, 0, mk(32'(i), 0, 1, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL idle_inc: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   idle_inc pc=%h", o.pc);
    end
  endtask

  task automatic test_branch();
    rec_t e, o;
    apply(0, 0, 0,        0, 0, mk(32'h5,  0, 1, 0, 0));
    apply(0, 1, 32'h40,   0, 0, mk(32'h40, 1, 0, 1, 0));
    apply(1, 1, 32'h99,   0, 0, mk(32'h40, 0, 0, 1, 0)); // ignored while flushing
    apply(0, 0, 0,        0, 0, mk(32'h40, 0, 1, 0, 0));
    apply(0, 0, 0,        0, 0, mk(32'h41, 0, 1, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_flush: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   branch_flush pc=%h fl=%b", o.pc, o.fl);
    end
  endtask

  task automatic test_branch_stall();
    rec_t e, o;
    apply(0, 1, 32'h7,  0, 0, mk(32'h7,  1, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h7,  0, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h7,  0, 1, 0, 0));
    apply(1, 1, 32'h10, 0, 0, mk(32'h10, 1, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h10, 0, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h10, 0, 1, 0, 0));
    apply(0, 1, 32'h9,  0, 0, mk(32'h9,  1, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h9,  0, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h9,  0, 1, 0, 0));
    apply(1, 0, 0,      0, 0, mk(32'h9,  0, 1, 0, 0));
    apply(1, 0, 0,      0, 0, mk(32'h9,  0, 1, 0, 0));
    apply(0, 0, 0,      0, 0, mk(32'hA,  0, 1, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_stall: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   branch_stall pc=%h", o.pc);
    end
  endtask

  task automatic test_halt();
    rec_t e, o;
    apply(0, 1, 32'h3, 0, 0, mk(32'h3, 1, 0, 1, 0));
    apply(0, 0, 0,     0, 0, mk(32'h3, 0, 0, 1, 0));
    apply(0, 0, 0,     0, 0, mk(32'h3, 0, 1, 0, 0));
    apply(0, 0, 0,     1, 0, mk(32'h3, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      apply(0, (i == 2), 32'h77, 1, 0, mk(32'h3, 0, 0, 0, 1));
    apply(0, 0, 0,     1, 1, mk(32'h3, 0, 0, 0, 1));
    apply(0, 0, 0,     0, 1, mk(32'h3, 0, 1, 0, 0));
    apply(0, 0, 0,     0, 0, mk(32'h4, 0, 1, 0, 0));
    apply(0, 1, 32'h55, 1, 0, mk(32'h4, 0, 0, 0, 1)); // halt outranks branch
    apply(0, 0, 0,     0, 1, mk(32'h4, 0, 1, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL halt_resume: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   halt_resume pc=%h hl=%b", o.pc, o.hl);
    end
  endtask

  task automatic test_wrap_and_reset();
    rec_t e, o;
    apply(0, 1, 32'hFFFF_FFFF, 0, 0, mk(32'hFFFF_FFFF, 1, 0, 1, 0));
    apply(0, 0, 0, 0, 0, mk(32'hFFFF_FFFF, 0, 0, 1, 0));
    apply(0, 0, 0, 0, 0, mk(32'hFFFF_FFFF, 0, 1, 0, 0));
    apply(0, 0, 0, 0, 0, mk(32'h0, 0, 1, 0, 0));
    apply(0, 0, 0, 0, 0, mk(32'h1, 0, 1, 0, 0));
    apply(0, 1, 32'h50, 0, 0, mk(32'h50, 1, 0, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   wrap pc=%h", o.pc);
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.pc, bus.flush, bus.halted, bus.fetch_valid} !== {32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_in_flush: got pc=%h flush=%b halted=%b fv=%b, need pc=0 flush=0 halted=0 fv=1",
               bus.pc, bus.flush, bus.halted, bus.fetch_valid);
    end else $display("ok   reset_in_flush pc=%h", bus.pc);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(0, 0, 0, 0, 0, mk(32'h1, 0, 1, 0, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL after_reset: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   after_reset pc=%h", o.pc);
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_branch_count();
    rec_t e, o;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (branch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL count_reset: got %0d, need 0", branch_count);
    end else $display("ok   count_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(0, 1, 32'h20, 0, 0, mk(32'h20, 1, 0, 1, 0));
    apply(0, 1, 32'h21, 0, 0, mk(32'h20, 0, 0, 1, 0));
    apply(0, 1, 32'h22, 0, 0, mk(32'h20, 0, 1, 0, 0));
    apply(0, 1, 32'h30, 0, 0, mk(32'h30, 1, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h30, 0, 0, 1, 0));
    apply(0, 0, 0,      0, 0, mk(32'h30, 0, 1, 0, 0));
    apply(0, 1, 32'h33, 1, 0, mk(32'h30, 0, 0, 0, 1));
    apply(0, 1, 32'h34, 1, 0, mk(32'h30, 0, 0, 0, 1));
    apply(0, 0, 0,      0, 1, mk(32'h30, 0, 1, 0, 0));
    apply(0, 1, 32'h40, 0, 0, mk(32'h40, 1, 0, 1, 0));
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = obs.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL count_seq: got pc=%h mux=%b fv=%b fl=%b hl=%b, need pc=%h mux=%b fv=%b fl=%b hl=%b",
                 o.pc, o.mux, o.fv, o.fl, o.hl, e.pc, e.mux, e.fv, e.fl, e.hl);
      end else $display("ok   count_seq pc=%h", o.pc);
    end
    n_checks++;
    if (branch_count !== 16'd3) begin
      n_fail++;
      $display("FAIL branch_count: got %0d, need 3", branch_count);
    end else $display("ok   branch_count=%0d", branch_count);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_branch();
    test_branch_stall();
    test_halt();
    test_wrap_and_reset();
`ifdef BRANCH_STATS_EN
    test_branch_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
